// File: rtl/mesm6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesm6_pkg
// Description : Shared defaults and arbiter state encoding for the MESM6
//               two-master memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mesm6_pkg;

    // Default memory word address and data widths
    localparam int c_DEFAULT_ADDR_W = 15;
    localparam int c_DEFAULT_DATA_W = 48;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage : mesm6_pkg
`default_nettype wire

// File: rtl/mesm6_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mesm6_mem_arbiter
// Description : Round-robin arbiter giving two masters shared access to one
//               memory slave, with a per-transaction timeout that aborts a
//               stalled access and raises a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mesm6_mem_arbiter
    import mesm6_pkg::*;
#(
    parameter int ADDR_W  = c_DEFAULT_ADDR_W,
    parameter int DATA_W  = c_DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // master 0
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    // master 1
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    // slave
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_done,
    // status
    output logic [1:0]        grant,
    output logic              timeout_err
);

    // Counter holds TIMEOUT itself at the abort cycle, so it never wraps
    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [1:0]         r_grant;
    logic               r_last;      // master that finished most recently
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    logic               w_own;
    logic               w_sel;
    logic               w_rd;
    logic               w_wr;
    logic               w_req_act;
    logic               w_abort;
    logic               w_fin;
    logic               w_done;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_m0_req;
    logic               w_m1_req;

    assign grant       = r_grant;
    assign timeout_err = r_err;

    // Owner selection, completion/abort detection, slave and master muxing
    always_comb begin
        w_own     = (r_state != ST_IDLE);
        w_sel     = (r_state == ST_OWN1);
        w_rd      = w_sel ? m1_read  : m0_read;
        w_wr      = w_sel ? m1_write : m0_write;
        w_req_act = w_rd | w_wr;
        w_m0_req  = m0_read | m0_write;
        w_m1_req  = m1_read | m1_write;
        // s_done wins over a timeout landing in the same cycle
        w_abort   = w_own & w_req_act & ~s_done & (r_cnt == c_TMO);
        w_fin     = w_own & (s_done | w_abort | ~w_req_act);

        s_addr    = '0;
        s_wdata   = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        w_done    = 1'b0;
        w_rdata   = '0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;

        if (w_own) begin
            s_addr  = w_sel ? m1_addr  : m0_addr;
            s_wdata = w_sel ? m1_wdata : m0_wdata;
            // a combined read+write request is treated as a write
            s_write = w_wr & ~w_abort;
            s_read  = w_rd & ~w_wr & ~w_abort;
            w_done  = s_done | w_abort;
            w_rdata = w_abort ? {DATA_W{1'b1}} : s_rdata;
            if (w_sel) begin
                m1_done  = w_done;
                m1_rdata = w_rdata;
            end else begin
                m0_done  = w_done;
                m0_rdata = w_rdata;
            end
        end

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_m0_req && w_m1_req)
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                else if (w_m0_req)
                    w_state_nxt = ST_OWN0;
                else if (w_m1_req)
                    w_state_nxt = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (w_fin)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, grant, round-robin pointer, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= {w_state_nxt == ST_OWN1, w_state_nxt == ST_OWN0};
            if (w_fin)
                r_last <= w_sel;
            if (!w_own || w_fin)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_ONE;
            if (w_abort)
                r_err <= 1'b1;
        end
    end

endmodule : mesm6_mem_arbiter
`default_nettype wire

// File: tb/tb_mesm6_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesm6_mem_arbiter
// Description : Directed, table-driven bench for mesm6_mem_arbiter with
//               hand-written timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesm6_mem_arbiter;

    localparam int c_AW  = 15;
    localparam int c_DW  = 48;
    localparam int c_TMO = 4;

    localparam logic [c_AW-1:0] c_A0  = 15'h0010;
    localparam logic [c_AW-1:0] c_A1  = 15'h7FFF;
    localparam logic [c_DW-1:0] c_W0  = 48'hA5A5_0000_5A5A;
    localparam logic [c_DW-1:0] c_W1  = 48'hFFFF_FFFF_FFFF;
    localparam logic [c_DW-1:0] c_RD  = 48'h1234_5678_9ABC;
    localparam logic [c_DW-1:0] c_ONES = {c_DW{1'b1}};

    logic            clk = 1'b0;
    logic            reset;
    logic [c_AW-1:0] m0_addr, m1_addr, s_addr;
    logic            m0_read, m0_write, m1_read, m1_write;
    logic [c_DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic            m0_done, m1_done;
    logic            s_read, s_write, s_done;
    logic [c_DW-1:0] s_wdata, s_rdata;
    logic [1:0]      grant;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mesm6_mem_arbiter #(
        .ADDR_W  (c_AW),
        .DATA_W  (c_DW),
        .TIMEOUT (c_TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_addr     (m0_addr),
        .m0_read     (m0_read),
        .m0_write    (m0_write),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m0_done     (m0_done),
        .m1_addr     (m1_addr),
        .m1_read     (m1_read),
        .m1_write    (m1_write),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .m1_done     (m1_done),
        .s_addr      (s_addr),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_done      (s_done),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [4:0]      in;   // {m0r, m0w, m1r, m1w, s_done}
        logic [1:0]      g;
        logic [3:0]      o;    // {s_read, s_write, m0_done, m1_done}
        logic [c_AW-1:0] a;
        logic [c_DW-1:0] wd;
        logic [c_DW-1:0] r0;
        logic [c_DW-1:0] r1;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g,
                                input logic [3:0] o, input logic [c_AW-1:0] a,
                                input logic [c_DW-1:0] wd, input logic [c_DW-1:0] r0,
                                input logic [c_DW-1:0] r1);
        vec_t v;
        v.in = in; v.g = g; v.o = o; v.a = a; v.wd = wd; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {m0_read, m0_write, m1_read, m1_write, s_done} = in;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] g, input logic [3:0] o,
                              input logic [c_AW-1:0] a, input logic [c_DW-1:0] wd,
                              input logic [c_DW-1:0] r0, input logic [c_DW-1:0] r1,
                              input logic err);
        chk({tag, " grant"},   64'(grant),       64'(g));
        chk({tag, " s_read"},  64'(s_read),      64'(o[3]));
        chk({tag, " s_write"}, 64'(s_write),     64'(o[2]));
        chk({tag, " m0_done"}, 64'(m0_done),     64'(o[1]));
        chk({tag, " m1_done"}, 64'(m1_done),     64'(o[0]));
        chk({tag, " s_addr"},  64'(s_addr),      64'(a));
        chk({tag, " s_wdata"}, 64'(s_wdata),     64'(wd));
        chk({tag, " m0_rdata"},64'(m0_rdata),    64'(r0));
        chk({tag, " m1_rdata"},64'(m1_rdata),    64'(r1));
        chk({tag, " tmo_err"}, 64'(timeout_err), 64'(err));
    endtask

    // inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(5'b00000);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        m0_addr = c_A0; m1_addr = c_A1;
        m0_wdata = c_W0; m1_wdata = c_W1;
        s_rdata = c_RD;
        reset = 1'b1;
        drive(5'b00000);

        //                in        g      o       a     wd    r0    r1
        vecs[0]  = mk(5'b10100, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[1]  = mk(5'b10100, 2'b01, 4'b1000, c_A0, c_W0, c_RD, '0);
        vecs[2]  = mk(5'b10101, 2'b01, 4'b1010, c_A0, c_W0, c_RD, '0);
        vecs[3]  = mk(5'b10100, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[4]  = mk(5'b10100, 2'b10, 4'b1000, c_A1, c_W1, '0,   c_RD);
        vecs[5]  = mk(5'b10101, 2'b10, 4'b1001, c_A1, c_W1, '0,   c_RD);
        vecs[6]  = mk(5'b10000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[7]  = mk(5'b10000, 2'b01, 4'b1000, c_A0, c_W0, c_RD, '0);
        vecs[8]  = mk(5'b10000, 2'b01, 4'b1000, c_A0, c_W0, c_RD, '0);
        vecs[9]  = mk(5'b10001, 2'b01, 4'b1010, c_A0, c_W0, c_RD, '0);
        vecs[10] = mk(5'b00000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[11] = mk(5'b00110, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[12] = mk(5'b00110, 2'b10, 4'b0100, c_A1, c_W1, '0,   c_RD);
        vecs[13] = mk(5'b00111, 2'b10, 4'b0101, c_A1, c_W1, '0,   c_RD);
        vecs[14] = mk(5'b00000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[15] = mk(5'b01000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[16] = mk(5'b01000, 2'b01, 4'b0100, c_A0, c_W0, c_RD, '0);
        vecs[17] = mk(5'b00000, 2'b01, 4'b0000, c_A0, c_W0, c_RD, '0);
        vecs[18] = mk(5'b00000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[19] = mk(5'b00001, 2'b00, 4'b0000, '0,   '0,   '0,   '0);
        vecs[20] = mk(5'b00000, 2'b00, 4'b0000, '0,   '0,   '0,   '0);

        // reset state
        next_cycle();
        @(negedge clk);
        check_outs("reset", 2'b00, 4'b0000, '0, '0, '0, '0, 1'b0);
        next_cycle();
        reset = 1'b0;

        // table: tie-break, round robin, read latency, write priority, withdrawal, stray s_done
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].in);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].g, vecs[i].o, vecs[i].a,
                       vecs[i].wd, vecs[i].r0, vecs[i].r1, 1'b0);
            next_cycle();
        end

        // timeout: slave never answers, abort in the cycle the counter hits TIMEOUT
        drive(5'b10000);
        @(negedge clk);
        chk("tmo idle grant", 64'(grant), 64'(2'b00));
        next_cycle();
        for (int k = 0; k < c_TMO; k++) begin
            @(negedge clk);
            chk($sformatf("tmo wait%0d m0_done", k), 64'(m0_done), 64'(0));
            chk($sformatf("tmo wait%0d s_read", k), 64'(s_read), 64'(1));
            next_cycle();
        end
        @(negedge clk);
        check_outs("tmo abort", 2'b01, 4'b0010, c_A0, c_W0, c_ONES, '0, 1'b0);
        next_cycle();
        drive(5'b00000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_outs($sformatf("tmo after%0d", k), 2'b00, 4'b0000, '0, '0, '0, '0, 1'b1);
            next_cycle();
        end
        do_reset();
        @(negedge clk);
        chk("tmo cleared by reset", 64'(timeout_err), 64'(0));

        // s_done arriving in the counter's final cycle is a normal completion
        drive(5'b10000);
        next_cycle();
        for (int k = 0; k < c_TMO; k++) next_cycle();
        drive(5'b10001);
        @(negedge clk);
        check_outs("edge done", 2'b01, 4'b1010, c_A0, c_W0, c_RD, '0, 1'b0);
        next_cycle();
        drive(5'b00000);
        @(negedge clk);
        check_outs("edge after", 2'b00, 4'b0000, '0, '0, '0, '0, 1'b0);
        next_cycle();

        // reset in the middle of an m1 transaction
        drive(5'b00100);
        next_cycle();
        @(negedge clk);
        chk("rst own1 grant", 64'(grant), 64'(2'b10));
        next_cycle();
        reset = 1'b1;
        drive(5'b10100);
        next_cycle();
        reset = 1'b0;
        drive(5'b10101);
        @(negedge clk);
        check_outs("rst drop", 2'b00, 4'b0000, '0, '0, '0, '0, 1'b0);
        next_cycle();
        drive(5'b10100);
        @(negedge clk);
        chk("rst m0 first grant", 64'(grant), 64'(2'b01));
        chk("rst m0 first addr", 64'(s_addr), 64'(c_A0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mesm6_mem_arbiter
`default_nettype wire
